counter_timestamp_capture: RTL and testbench

- Downstream consumer of a free-running 16-bit up counter (counterup16-style) in the same clock domain.
- On each rising edge of an event strobe, snapshots the counter value into a small FIFO.
- The FIFO drains through a valid/ready handshake.
- Sticky overflow flag records events lost because the FIFO was full.

---
 rtl/counter_timestamp_capture.sv | 99 +++++++++
 tb/tb_counter_timestamp_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_timestamp_capture.sv
// Captures a running counter value into a small FWFT FIFO on each armed rising edge of event_in.
// Optional build macro CAPTURE_DELTA_EN stores the interval since the previous armed event instead of the raw count.
module counter_timestamp_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count,
    input  logic                     event_in,
    input  logic                     arm,
    output logic [WIDTH-1:0]         ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             event_prev_q, event_prev_d;
    logic             rise, pop, push_ok, drop;
    logic [WIDTH-1:0] entry;

`ifdef CAPTURE_DELTA_EN
    logic [WIDTH-1:0] base_q, base_d;

    // The base follows every armed edge, even dropped ones, so a delta is always relative to the previous armed event.
    always_comb begin
        base_d = rise ? count : base_q;
        entry  = count - base_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end
`else
    assign entry = count;
`endif

    assign ts_valid = (level_q != '0);
    assign ts_data  = ts_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;

    always_comb begin
        rise         = event_in & ~event_prev_q & arm;
        pop          = ts_valid & ts_ready;
        push_ok      = rise & ((level_q != FULL_LEVEL) | pop);
        drop         = rise & ~push_ok;
        event_prev_d = event_in;
        wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d      = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push_ok) begin
            level_d = level_q - 1'b1;
        end
        overflow_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : overflow_q);
    end

    // event_prev resets high so a strobe already asserted at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            event_prev_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            event_prev_q <= event_prev_d;
        end
    end

    // Storage needs no reset: ts_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

endmodule

// File: tb/tb_counter_timestamp_capture.sv
// Self-checking bench for counter_timestamp_capture: directed scenarios plus randomized traffic against a queue model.
// Expectations follow the CAPTURE_DELTA_EN macro when it is defined for the build.
module tb_counter_timestamp_capture;

`ifdef CAPTURE_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] count;
    logic        eventIn;
    logic        arm;
    logic [15:0] tsData;
    logic        tsValid;
    logic        tsReady;
    logic [2:0]  level;
    logic        overflow;
    logic        ovfClear;

    int numCompared   = 0;
    int numMismatched = 0;

    logic [15:0] mQ [$];
    logic        mPrev;
    logic [15:0] mBase;
    logic        mOvf;
    logic        mRise;
    logic        mDrop;

    counter_timestamp_capture #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .event_in (eventIn),
        .arm      (arm),
        .ts_data  (tsData),
        .ts_valid (tsValid),
        .ts_ready (tsReady),
        .level    (level),
        .overflow (overflow),
        .ovf_clear(ovfClear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] expEntry(input logic [15:0] cnt, input logic [15:0] prev);
        return cnt - (DELTA ? prev : 16'h0000);
    endfunction

    // Reference model: a queue of timestamps; pop happens before push so a full FIFO with a pop accepts the event.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mQ.delete();
            mPrev = 1'b1;
            mBase = 16'h0000;
            mOvf  = 1'b0;
        end else begin
            mRise = eventIn && !mPrev && arm;
            mDrop = 1'b0;
            if (mQ.size() > 0 && tsReady) void'(mQ.pop_front());
            if (mRise) begin
                if (mQ.size() < DEPTH) mQ.push_back(expEntry(count, mBase));
                else mDrop = 1'b1;
                mBase = count;
            end
            if (mDrop) mOvf = 1'b1;
            else if (ovfClear) mOvf = 1'b0;
            mPrev = eventIn;
        end
    end

    always @(negedge clk) begin
        checkOutput("model_valid", tsValid, mQ.size() != 0);
        checkOutput("model_level", level, mQ.size());
        checkOutput("model_data", tsData, (mQ.size() != 0) ? mQ[0] : 16'h0000);
        checkOutput("model_ovf", overflow, mOvf);
    end

    task automatic applyStimulus(input logic ev, input logic ar, input logic rdy, input logic clr,
                                 input logic [15:0] cnt);
        eventIn  = ev;
        arm      = ar;
        tsReady  = rdy;
        ovfClear = clr;
        count    = cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vals [4];
        logic [15:0] prevs [4];
        logic [15:0] cnt;

        reset = 1'b0; eventIn = 1'b1; arm = 1'b1; tsReady = 1'b0; ovfClear = 1'b0; count = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", level, 0);
        checkOutput("rst_valid", tsValid, 0);
        checkOutput("rst_data", tsData, 0);
        checkOutput("rst_ovf", overflow, 0);

        // Strobe held high across reset release must not be captured.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'(i));
        checkOutput("hold_level", level, 0);
        checkOutput("hold_valid", tsValid, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h000f);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010);
        checkOutput("single_valid", tsValid, 1);
        checkOutput("single_data", tsData, 16'h0010);
        checkOutput("single_level", level, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0011);
        checkOutput("single_pop_level", level, 0);
        checkOutput("single_pop_valid", tsValid, 0);

        vals  = '{16'd5, 16'd9, 16'd13, 16'd17};
        prevs = '{16'h0010, 16'd5, 16'd9, 16'd13};
        for (int i = 0; i < 5; i++) begin
            cnt = 16'(5 + 4 * i);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cnt);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, cnt + 16'd1);
        end
        checkOutput("ovf_level", level, 4);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_hold_data", tsData, expEntry(16'd5, 16'h0010));
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_drain_data", tsData, expEntry(vals[i], prevs[i]));
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd30);
        end
        checkOutput("ovf_drain_empty", tsValid, 0);
        checkOutput("ovf_still_set", overflow, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'd31);
        checkOutput("ovf_cleared", overflow, 0);

        for (int i = 0; i < 4; i++) begin
            cnt = 16'(50 + 2 * i);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, cnt);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, cnt + 16'd1);
        end
        checkOutput("full_level", level, 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'd40);
        checkOutput("full_pp_ovf", overflow, 0);
        checkOutput("full_pp_level", level, 4);
        vals  = '{16'd52, 16'd54, 16'd56, 16'd40};
        prevs = '{16'd50, 16'd52, 16'd54, 16'd56};
        for (int i = 0; i < 4; i++) begin
            checkOutput(i == 3 ? "full_pp_last" : "full_pp_drain", tsData, expEntry(vals[i], prevs[i]));
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd41);
        end
        checkOutput("full_pp_empty", tsValid, 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd101);
        checkOutput("disarmed_level", level, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'd200);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd201);
        checkOutput("armed_level", level, 1);
        checkOutput("armed_data", tsData, expEntry(16'd200, 16'd40));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd202);

        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'hffef);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hfff0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'hfff1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0011);
        checkOutput("wrap_level", level, 2);
        checkOutput("wrap_first", tsData, 16'hfff0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0012);
        checkOutput("wrap_second", tsData, DELTA ? 16'h0020 : 16'h0010);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0013);

        // Random traffic with occasional asynchronous resets landing mid-cycle.
        cnt = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2 reset = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
            end
            cnt = ($urandom_range(0, 19) == 0) ? 16'($urandom) : cnt + 16'd1;
            applyStimulus($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 85,
                          $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 5, cnt);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
